branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 180 ++++++++++++++++++
 tb/tb_branch_resolve.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: queues predictions, resolves them against incoming flags,
// flushes on mispredict and reports each outcome to the predictor. Optional counters: BRES_STATS_EN.
module branch_resolve #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pred_valid,
   output logic        pred_ready,
   input  logic        pred_taken,
   input  logic [15:0] pred_pc,
   input  logic [15:0] pred_target,
   input  logic [4:0]  jumpType,
   input  logic        flags_valid,
   input  logic [11:0] statusBits,
   output logic        flush,
   output logic [15:0] redirect_pc,
   output logic        upd_valid,
   input  logic        upd_ready,
   output logic [7:0]  upd_addr,
   output logic        upd_taken,
   output logic        upd_correct,
   output logic        busy
`ifdef BRES_STATS_EN
   ,
   output logic [15:0] resolve_count,
   output logic [15:0] mispred_count
`endif
);

   // state | meaning
   // IDLE  | waiting for flags with a non-empty queue
   // EVAL  | resolving the head entry, flush on mismatch
   // UPD   | presenting predictor update until accepted
   typedef enum logic [1:0] {IDLE, EVAL, UPD} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]  flags_q, flags_d;
   logic [15:0] redirect_q, redirect_d;
   logic [7:0]  upd_addr_q, upd_addr_d;
   logic        upd_taken_q, upd_taken_d;
   logic        upd_correct_q, upd_correct_d;

   logic        taken_mem [DEPTH];
   logic [15:0] pc_mem    [DEPTH];
   logic [15:0] tgt_mem   [DEPTH];
   logic [4:0]  jt_mem    [DEPTH];

   logic        empty, full, push, pop, actual, mispred_evt;
   logic        head_taken;
   logic [15:0] head_pc, head_tgt;
   logic [4:0]  head_jt;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_taken = taken_mem[rd_ptr_q[AW-1:0]];
   assign head_pc    = pc_mem[rd_ptr_q[AW-1:0]];
   assign head_tgt   = tgt_mem[rd_ptr_q[AW-1:0]];
   assign head_jt    = jt_mem[rd_ptr_q[AW-1:0]];

   // flags_q = {C, N, V, Z}
   always_comb begin
      actual = 1'b0;
      case (head_jt)
         5'b10000: actual = flags_q[3];
         5'b01000: actual = flags_q[2];
         5'b00100: actual = flags_q[1];
         5'b00010: actual = flags_q[0];
         5'b01110: actual = !flags_q[3];
         5'b10110: actual = !flags_q[2];
         5'b11010: actual = !flags_q[1];
         5'b11100: actual = !flags_q[0];
         default:  actual = 1'b0;
      endcase
   end

   assign mispred_evt = (state_q == EVAL) && (actual != head_taken);
   assign pred_ready  = !reset && !full && !mispred_evt;
   assign push        = pred_valid && pred_ready;
   assign pop         = (state_q == UPD) && upd_ready;
   assign flush       = mispred_evt && !reset;
   assign redirect_pc = flush ? (actual ? head_tgt : head_pc + 16'd1) : redirect_q;
   assign upd_valid   = (state_q == UPD);
   assign upd_addr    = upd_addr_q;
   assign upd_taken   = upd_taken_q;
   assign upd_correct = upd_correct_q;
   assign busy        = !empty || (state_q != IDLE);

   always_comb begin
      state_d       = state_q;
      flags_d       = flags_q;
      redirect_d    = redirect_pc;
      upd_addr_d    = upd_addr_q;
      upd_taken_d   = upd_taken_q;
      upd_correct_d = upd_correct_q;
      rd_ptr_d      = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      // A mispredict keeps only the head; everything younger is on the wrong path.
      if (mispred_evt)
         wr_ptr_d = rd_ptr_q + PTR_ONE;
      else if (push)
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      else
         wr_ptr_d = wr_ptr_q;
      case (state_q)
         IDLE: if (!empty && flags_valid) begin
            state_d = EVAL;
            flags_d = statusBits[11:8];
         end
         EVAL: begin
            state_d       = UPD;
            upd_addr_d    = head_pc[7:0];
            upd_taken_d   = actual;
            upd_correct_d = !mispred_evt;
         end
         UPD: if (upd_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         flags_q       <= '0;
         redirect_q    <= '0;
         upd_addr_q    <= '0;
         upd_taken_q   <= 1'b0;
         upd_correct_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         flags_q       <= flags_d;
         redirect_q    <= redirect_d;
         upd_addr_q    <= upd_addr_d;
         upd_taken_q   <= upd_taken_d;
         upd_correct_q <= upd_correct_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         taken_mem[wr_ptr_q[AW-1:0]] <= pred_taken;
         pc_mem[wr_ptr_q[AW-1:0]]    <= pred_pc;
         tgt_mem[wr_ptr_q[AW-1:0]]   <= pred_target;
         jt_mem[wr_ptr_q[AW-1:0]]    <= jumpType;
      end
   end

`ifdef BRES_STATS_EN
   logic [15:0] resolve_q, resolve_d, mispred_q, mispred_d;

   always_comb begin
      resolve_d = resolve_q;
      mispred_d = mispred_q;
      if (pop && resolve_q != 16'hFFFF) resolve_d = resolve_q + 16'd1;
      if (mispred_evt && mispred_q != 16'hFFFF) mispred_d = mispred_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         resolve_q <= '0;
         mispred_q <= '0;
      end else begin
         resolve_q <= resolve_d;
         mispred_q <= mispred_d;
      end
   end

   assign resolve_count = resolve_q;
   assign mispred_count = mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (DEPTH=4).
module tb_branch_resolve;
   logic        clk = 1'b0;
   logic        reset, pred_valid, pred_ready, pred_taken;
   logic [15:0] pred_pc, pred_target;
   logic [4:0]  jumpType;
   logic        flags_valid;
   logic [11:0] statusBits;
   logic        flush;
   logic [15:0] redirect_pc;
   logic        upd_valid, upd_ready;
   logic [7:0]  upd_addr;
   logic        upd_taken, upd_correct, busy;
`ifdef BRES_STATS_EN
   logic [15:0] resolve_count, mispred_count;
`endif

   int errors = 0;
   int checks = 0;

   branch_resolve #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken),
      .pred_pc(pred_pc), .pred_target(pred_target), .jumpType(jumpType),
      .flags_valid(flags_valid), .statusBits(statusBits),
      .flush(flush), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
      .upd_taken(upd_taken), .upd_correct(upd_correct), .busy(busy)
`ifdef BRES_STATS_EN
      , .resolve_count(resolve_count), .mispred_count(mispred_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pred(input logic tk, input logic [15:0] pc, input logic [15:0] tgt,
                            input logic [4:0] jt);
      pred_valid = 1'b1; pred_taken = tk; pred_pc = pc; pred_target = tgt; jumpType = jt;
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %b exp 0", pred_ready); end
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", pred_ready); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
      checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL rst_redirect got %h exp 0000", redirect_pc); end
      checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL rst_upd_valid got %b exp 0", upd_valid); end
      checks++; if ({upd_addr, upd_taken, upd_correct} !== 10'd0) begin errors++; $display("FAIL rst_upd_fields got %h/%b/%b exp 0", upd_addr, upd_taken, upd_correct); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
   endtask

   task automatic test_match();
      push_pred(1'b1, 16'h0010, 16'h0040, 5'b11100);
      flags_valid = 1'b1; statusBits = 12'h000;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL match_busy got %b exp 1", busy); end
      tick();
      flags_valid = 1'b0;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL match_flush got %b exp 0", flush); end
      checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL match_redirect_hold got %h exp 0000", redirect_pc); end
      tick();
      checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL match_upd_valid got %b exp 1", upd_valid); end
      checks++; if ({upd_addr, upd_taken, upd_correct} !== {8'h10, 1'b1, 1'b1}) begin errors++; $display("FAIL match_upd got %h/%b/%b exp 10/1/1", upd_addr, upd_taken, upd_correct); end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
      checks++; if (upd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL match_done got valid=%b busy=%b exp 0/0", upd_valid, busy); end
   endtask

   task automatic test_mispredict();
      push_pred(1'b1, 16'h0020, 16'h0080, 5'b10000);
      flags_valid = 1'b1; statusBits = 12'h000;
      tick();
      flags_valid = 1'b0;
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush got %b exp 1", flush); end
      checks++; if (redirect_pc !== 16'h0021) begin errors++; $display("FAIL mis_redirect got %h exp 0021", redirect_pc); end
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL mis_ready got %b exp 0", pred_ready); end
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mis_flush_pulse got %b exp 0", flush); end
      checks++; if (redirect_pc !== 16'h0021) begin errors++; $display("FAIL mis_redirect_hold got %h exp 0021", redirect_pc); end
      checks++; if ({upd_valid, upd_addr, upd_taken, upd_correct} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin errors++; $display("FAIL mis_upd got %b/%h/%b/%b exp 1/20/0/0", upd_valid, upd_addr, upd_taken, upd_correct); end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
   endtask

   localparam logic [4:0]  JT [14] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b01110, 5'b01110, 5'b10110,
                                       5'b11010, 5'b11100, 5'b11100, 5'b00010, 5'b00000, 5'b11111, 5'b00010};
   localparam logic [11:0] ST [14] = '{12'h800, 12'h400, 12'h200, 12'h100, 12'h700, 12'h800, 12'hB00,
                                       12'hD00, 12'hE00, 12'h100, 12'hE00, 12'hF00, 12'hF00, 12'h0FF};
   localparam logic        EX [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic test_conditions();
      for (int i = 0; i < 14; i++) begin
         push_pred(1'b0, 16'h0100 + 16'(i), 16'h0200 + 16'(i), JT[i]);
         flags_valid = 1'b1; statusBits = ST[i];
         tick();
         flags_valid = 1'b0;
         checks++; if (flush !== EX[i]) begin errors++; $display("FAIL cond%0d_flush got %b exp %b", i, flush, EX[i]); end
         if (EX[i]) begin
            checks++; if (redirect_pc !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL cond%0d_redirect got %h exp %h", i, redirect_pc, 16'h0200 + 16'(i)); end
         end
         tick();
         checks++; if ({upd_addr, upd_taken, upd_correct} !== {8'(i), EX[i], !EX[i]}) begin errors++; $display("FAIL cond%0d_upd got %h/%b/%b exp %h/%b/%b", i, upd_addr, upd_taken, upd_correct, 8'(i), EX[i], !EX[i]); end
         upd_ready = 1'b1;
         tick();
         upd_ready = 1'b0;
      end
   endtask

   task automatic test_wrap_flush();
      push_pred(1'b1, 16'hFFFF, 16'h1234, 5'b01000);
      for (int i = 0; i < 3; i++) push_pred(1'b0, 16'h0030 + 16'(i), 16'h0000, 5'b00010);
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL wrap_full got %b exp 0", pred_ready); end
      flags_valid = 1'b1; statusBits = 12'h000;
      tick();
      flags_valid = 1'b0;
      checks++; if (flush !== 1'b1 || redirect_pc !== 16'h0000) begin errors++; $display("FAIL wrap_redirect got %b/%h exp 1/0000", flush, redirect_pc); end
      tick();
      checks++; if ({upd_addr, upd_taken, upd_correct} !== {8'hFF, 1'b0, 1'b0}) begin errors++; $display("FAIL wrap_upd got %h/%b/%b exp FF/0/0", upd_addr, upd_taken, upd_correct); end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
      checks++; if (busy !== 1'b0 || pred_ready !== 1'b1) begin errors++; $display("FAIL wrap_discard got busy=%b ready=%b exp 0/1", busy, pred_ready); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) push_pred(1'b1, 16'h0041 + 16'(i), 16'h0000, 5'b00010);
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", pred_ready); end
      flags_valid = 1'b1; statusBits = 12'h100;
      tick();
      flags_valid = 1'b0;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bp_flush got %b exp 0", flush); end
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++; if ({upd_valid, upd_addr, upd_taken, upd_correct} !== {1'b1, 8'h41, 1'b1, 1'b1}) begin errors++; $display("FAIL bp_hold%0d got %b/%h/%b/%b exp 1/41/1/1", c, upd_valid, upd_addr, upd_taken, upd_correct); end
         tick();
      end
      upd_ready = 1'b1;
      tick();
      upd_ready = 1'b0;
      flags_valid = 1'b1;
      tick();
      flags_valid = 1'b0;
      tick();
      pred_valid = 1'b1; pred_taken = 1'b1; pred_pc = 16'h0045; jumpType = 5'b00010;
      upd_ready = 1'b1;
      #1;
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL bp_pushpop_ready got %b exp 1", pred_ready); end
      tick();
      pred_valid = 1'b0; upd_ready = 1'b0;
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL bp_count3 got %b exp 1", pred_ready); end
      push_pred(1'b1, 16'h0046, 16'h0000, 5'b00010);
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL bp_count4 got %b exp 0", pred_ready); end
      for (int i = 0; i < 4; i++) begin
         flags_valid = 1'b1;
         tick();
         flags_valid = 1'b0;
         tick();
         checks++; if (upd_addr !== 8'h43 + 8'(i)) begin errors++; $display("FAIL bp_order%0d got %h exp %h", i, upd_addr, 8'h43 + 8'(i)); end
         upd_ready = 1'b1;
         tick();
         upd_ready = 1'b0;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", busy); end
   endtask

   task automatic test_reset_in_upd();
      push_pred(1'b0, 16'h0077, 16'h0099, 5'b10000);
      flags_valid = 1'b1; statusBits = 12'h800;
      tick();
      flags_valid = 1'b0;
      tick();
      checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL rupd_valid_before got %b exp 1", upd_valid); end
      reset = 1'b1;
      #1;
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL rupd_ready_during got %b exp 0", pred_ready); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (upd_valid !== 1'b0 || busy !== 1'b0 || pred_ready !== 1'b1) begin errors++; $display("FAIL rupd_after got valid=%b busy=%b ready=%b exp 0/0/1", upd_valid, busy, pred_ready); end
      checks++; if (redirect_pc !== 16'h0000 || upd_addr !== 8'h00) begin errors++; $display("FAIL rupd_regs got %h/%h exp 0000/00", redirect_pc, upd_addr); end
`ifdef BRES_STATS_EN
      checks++; if (resolve_count !== 16'd0 || mispred_count !== 16'd0) begin errors++; $display("FAIL rupd_stats got %h/%h exp 0/0", resolve_count, mispred_count); end
`endif
   endtask

   initial begin
      reset = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0; pred_target = '0;
      jumpType = '0; flags_valid = 1'b0; statusBits = '0; upd_ready = 1'b0;
      test_reset();
      test_match();
      test_mispredict();
      test_conditions();
      test_wrap_flush();
      test_back_to_back();
      test_reset_in_upd();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
